// File: rtl/uart_rx.sv
// UART receive engine: 16x oversampled framing of start/data/parity/stop bits
// into a valid/ready holding register with per-character error flags.
module uart_rx #(
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       rx,
  input  logic       cfg_en,
  input  logic [7:0] cfg_baud_div,
  input  logic [3:0] cfg_data_len,
  input  logic       cfg_parity_en,
  input  logic [1:0] cfg_parity_type,
  input  logic [1:0] cfg_stop_bits,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det,
  output logic       overrun_err,
  output logic       busy
);

  localparam int OW = $clog2(OVS);
  localparam logic [OW-1:0] MID = OW'(OVS / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  logic [7:0]             baud_cnt;
  logic [OW-1:0]          os_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_q;
  logic                   any_one;
  logic                   par_bad;
  logic                   frame_bad;

  logic [7:0]             sh_baud_div;
  logic [2:0]             sh_len;
  logic                   sh_par_en;
  logic [1:0]             sh_par_type;
  logic                   sh_two_stop;

  logic                   tick;
  logic                   mid_sample;
  logic                   start_edge;
  logic                   exp_par;

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign start_edge = rx_prev & ~rx_s & cfg_en;
  assign tick       = (state != IDLE) && (baud_cnt == sh_baud_div);
  assign mid_sample = tick && (os_cnt == MID);
  assign busy       = (state != IDLE);

  // Data bits above the configured length stay zero, so they do not disturb the XOR.
  always_comb begin
    exp_par = 1'b0;
    unique case (sh_par_type)
      2'b00:   exp_par = ^shift_q;
      2'b01:   exp_par = ~^shift_q;
      2'b10:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  // Synchronizer flops preset to the idle level so reset never looks like a start edge.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      any_one     <= 1'b0;
      par_bad     <= 1'b0;
      frame_bad   <= 1'b0;
      sh_baud_div <= '0;
      sh_len      <= '0;
      sh_par_en   <= 1'b0;
      sh_par_type <= '0;
      sh_two_stop <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;

      if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        break_det  <= 1'b0;
      end

      if (state == IDLE || tick) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 8'd1;
      end
      if (tick) begin
        os_cnt <= os_cnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state       <= START;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            shift_q     <= '0;
            any_one     <= 1'b0;
            par_bad     <= 1'b0;
            frame_bad   <= 1'b0;
            sh_baud_div <= cfg_baud_div;
            sh_len      <= (cfg_data_len > 4'd7) ? 3'd7 : cfg_data_len[2:0];
            sh_par_en   <= cfg_parity_en;
            sh_par_type <= cfg_parity_type;
            sh_two_stop <= (cfg_stop_bits != 2'b00);
          end
        end
        START: begin
          if (mid_sample) begin
            state <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (mid_sample) begin
            shift_q[bit_cnt] <= rx_s;
            any_one          <= any_one | rx_s;
            if (bit_cnt == sh_len) begin
              state <= sh_par_en ? PARITY : STOP1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (mid_sample) begin
            par_bad <= (rx_s != exp_par);
            any_one <= any_one | rx_s;
            state   <= STOP1;
          end
        end
        STOP1: begin
          if (mid_sample) begin
            frame_bad <= frame_bad | ~rx_s;
            any_one   <= any_one | rx_s;
            state     <= sh_two_stop ? STOP2 : DONE;
          end
        end
        STOP2: begin
          if (mid_sample) begin
            frame_bad <= frame_bad | ~rx_s;
            any_one   <= any_one | rx_s;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          // A consumer accepting in this very cycle frees the register for the new frame.
          if (!rx_valid || rx_ready) begin
            rx_data    <= shift_q;
            rx_valid   <= 1'b1;
            parity_err <= par_bad;
            frame_err  <= frame_bad;
            break_det  <= ~any_one;
          end else begin
            overrun_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (!cfg_en && state != IDLE && state != DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of framed characters plus hand-timed
// sequences for latency, break, false start, enable abort, overrun and reset.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       rx;
  logic       cfg_en;
  logic [7:0] cfg_baud_div;
  logic [3:0] cfg_data_len;
  logic       cfg_parity_en;
  logic [1:0] cfg_parity_type;
  logic [1:0] cfg_stop_bits;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;
  logic       overrun_err;
  logic       busy;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int bit_clks = 32;
  int ovr_cnt  = 0;
  int ovr_base = 0;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    logic [3:0] len;
    logic [7:0] div;
    logic       par_en;
    logic [1:0] ptype;
    logic       par_bit;
    logic [1:0] stop;
    logic       s1;
    logic       s2;
    logic [7:0] exp_data;
    logic       exp_par;
    logic       exp_frame;
    logic       exp_brk;
  } vec_t;

  vec_t vecs[11];

  uart_rx #(.OVS(16), .SYNC_STAGES(2)) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .rx              (rx),
    .cfg_en          (cfg_en),
    .cfg_baud_div    (cfg_baud_div),
    .cfg_data_len    (cfg_data_len),
    .cfg_parity_en   (cfg_parity_en),
    .cfg_parity_type (cfg_parity_type),
    .cfg_stop_bits   (cfg_stop_bits),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .parity_err      (parity_err),
    .frame_err       (frame_err),
    .break_det       (break_det),
    .overrun_err     (overrun_err),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun_err === 1'b1) ovr_cnt++;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (bit_clks) @(posedge clk);
    #1;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic set_8n1();
    cfg_baud_div    = 8'd1;
    cfg_data_len    = 4'd7;
    cfg_parity_en   = 1'b0;
    cfg_parity_type = 2'b00;
    cfg_stop_bits   = 2'b00;
    bit_clks        = 32;
  endtask

  task automatic send_byte(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b1);
    rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Configuration is scrambled once the start bit is out; the captured copy must rule the frame.
  task automatic applyStimulus(input vec_t v);
    cfg_baud_div    = v.div;
    cfg_data_len    = v.len;
    cfg_parity_en   = v.par_en;
    cfg_parity_type = v.ptype;
    cfg_stop_bits   = v.stop;
    bit_clks        = 16 * (int'(v.div) + 1);
    repeat (4) @(posedge clk);
    #1;
    drive_bit(1'b0);
    cfg_baud_div    = v.div + 8'd3;
    cfg_data_len    = v.len ^ 4'd3;
    cfg_parity_en   = ~v.par_en;
    cfg_parity_type = ~v.ptype;
    cfg_stop_bits   = (v.stop == 2'b00) ? 2'b01 : 2'b00;
    for (int i = 0; i < v.nbits; i++) drive_bit(v.data[i]);
    if (v.par_en) drive_bit(v.par_bit);
    drive_bit(v.s1);
    if (v.stop != 2'b00) drive_bit(v.s2);
    rx = 1'b1;
    cfg_baud_div    = v.div;
    cfg_data_len    = v.len;
    cfg_parity_en   = v.par_en;
    cfg_parity_type = v.ptype;
    cfg_stop_bits   = v.stop;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    //           data   nb len    div   pen ptype pb  stop   s1 s2  exp    ep ef eb
    vecs[0]  = '{8'hA5, 8, 4'd7, 8'd1, 0, 2'b00, 0, 2'b00, 1, 1, 8'hA5, 0, 0, 0};
    vecs[1]  = '{8'h35, 7, 4'd6, 8'd1, 1, 2'b00, 0, 2'b00, 1, 1, 8'h35, 0, 0, 0};
    vecs[2]  = '{8'h35, 7, 4'd6, 8'd1, 1, 2'b00, 1, 2'b00, 1, 1, 8'h35, 1, 0, 0};
    vecs[3]  = '{8'h3C, 8, 4'd7, 8'd0, 0, 2'b00, 0, 2'b01, 1, 0, 8'h3C, 0, 1, 0};
    vecs[4]  = '{8'h0F, 8, 4'd7, 8'd2, 1, 2'b01, 1, 2'b00, 1, 1, 8'h0F, 0, 0, 0};
    vecs[5]  = '{8'h15, 5, 4'd4, 8'd3, 1, 2'b10, 0, 2'b00, 1, 1, 8'h15, 1, 0, 0};
    vecs[6]  = '{8'h2A, 6, 4'd5, 8'd0, 1, 2'b11, 0, 2'b00, 1, 1, 8'h2A, 0, 0, 0};
    vecs[7]  = '{8'hC3, 8, 4'd9, 8'd1, 0, 2'b00, 0, 2'b00, 1, 1, 8'hC3, 0, 0, 0};
    vecs[8]  = '{8'hFF, 5, 4'd4, 8'd1, 0, 2'b00, 0, 2'b00, 1, 1, 8'h1F, 0, 0, 0};
    vecs[9]  = '{8'h5D, 8, 4'd7, 8'd1, 1, 2'b00, 1, 2'b10, 1, 1, 8'h5D, 0, 0, 0};
    vecs[10] = '{8'h80, 8, 4'd7, 8'd1, 0, 2'b00, 0, 2'b00, 0, 1, 8'h80, 0, 1, 0};

    arst_n   = 1'b0;
    rx       = 1'b1;
    cfg_en   = 1'b1;
    rx_ready = 1'b0;
    set_8n1();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset rx_valid", rx_valid, 8'd0);
    checkOutput("reset rx_data", rx_data, 8'd0);
    checkOutput("reset busy", busy, 8'd0);
    checkOutput("reset errors", {4'd0, parity_err, frame_err, break_det, overrun_err}, 8'd0);
    arst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Exact latency: stop bit driven after edge 288, final sample at edge 307, load at 308.
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(logic'(8'hA5 >> i));
    rx = 1'b1;
    repeat (19) @(posedge clk);
    #1;
    checkOutput("lat pre rx_valid", rx_valid, 8'd0);
    checkOutput("lat pre busy", busy, 8'd1);
    @(posedge clk);
    #1;
    checkOutput("lat rx_valid", rx_valid, 8'd1);
    checkOutput("lat rx_data", rx_data, 8'hA5);
    checkOutput("lat busy", busy, 8'd0);
    checkOutput("lat errors", {5'd0, parity_err, frame_err, break_det}, 8'd0);
    repeat (20) @(posedge clk);
    #1;
    consume();
    checkOutput("lat consumed", rx_valid, 8'd0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d rx_valid", i), rx_valid, 8'd1);
      checkOutput($sformatf("v%0d rx_data", i), rx_data, vecs[i].exp_data);
      checkOutput($sformatf("v%0d parity_err", i), parity_err, vecs[i].exp_par);
      checkOutput($sformatf("v%0d frame_err", i), frame_err, vecs[i].exp_frame);
      checkOutput($sformatf("v%0d break_det", i), break_det, vecs[i].exp_brk);
      consume();
      checkOutput($sformatf("v%0d cleared", i), {6'd0, rx_valid, frame_err}, 8'd0);
    end

    set_8n1();
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("break rx_valid", rx_valid, 8'd1);
    checkOutput("break rx_data", rx_data, 8'h00);
    checkOutput("break frame_err", frame_err, 8'd1);
    checkOutput("break break_det", break_det, 8'd1);
    checkOutput("break parity_err", parity_err, 8'd0);
    consume();

    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rx = 1'b1;
    checkOutput("glitch busy", busy, 8'd1);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("glitch idle", busy, 8'd0);
    checkOutput("glitch rx_valid", rx_valid, 8'd0);

    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    checkOutput("abort busy before", busy, 8'd1);
    cfg_en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort busy after", busy, 8'd0);
    for (int i = 0; i < 6; i++) drive_bit(1'b0);
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    cfg_en = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("abort rx_valid", rx_valid, 8'd0);
    checkOutput("abort busy idle", busy, 8'd0);

    send_byte(8'h11);
    checkOutput("ovr first rx_data", rx_data, 8'h11);
    ovr_base = ovr_cnt;
    send_byte(8'h22);
    checkOutput("ovr kept rx_data", rx_data, 8'h11);
    checkOutput("ovr kept rx_valid", rx_valid, 8'd1);
    checkOutput("ovr pulse count", 8'(ovr_cnt - ovr_base), 8'd1);

    ovr_base = ovr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(logic'(8'h22 >> i));
    rx = 1'b1;
    repeat (19) @(posedge clk);
    #1;
    checkOutput("done-cycle busy", busy, 8'd1);
    checkOutput("done-cycle old data", rx_data, 8'h11);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    checkOutput("replace rx_data", rx_data, 8'h22);
    checkOutput("replace rx_valid", rx_valid, 8'd1);
    checkOutput("replace no overrun", 8'(ovr_cnt - ovr_base), 8'd0);
    repeat (20) @(posedge clk);
    #1;

    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(logic'(8'h5A >> i));
    checkOutput("pre-reset rx_valid", rx_valid, 8'd1);
    checkOutput("pre-reset busy", busy, 8'd1);
    #2;
    arst_n = 1'b0;
    #1;
    checkOutput("async rx_valid", rx_valid, 8'd0);
    checkOutput("async rx_data", rx_data, 8'd0);
    checkOutput("async busy", busy, 8'd0);
    checkOutput("async errors", {4'd0, parity_err, frame_err, break_det, overrun_err}, 8'd0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    arst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send_byte(8'h5A);
    checkOutput("post-reset rx_valid", rx_valid, 8'd1);
    checkOutput("post-reset rx_data", rx_data, 8'h5A);
    checkOutput("post-reset errors", {5'd0, parity_err, frame_err, break_det}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive engine for the uart_ip block. It oversamples the rx line at 16x, frames start, data, parity and stop bits according to the live configuration, and presents each received character on a valid/ready holding register. Per-character errors (parity, framing, break) and overrun are also reported. The uart_ip status register reads these outputs directly.

Parameters:
OVS, 16, oversampling ticks per bit (fixed at 16; mid-bit = tick 7)
SYNC_STAGES, 2, rx input synchronizer depth

Ports:
clk  input  1  system clock
arst_n  input  1  asynchronous active-low reset
rx  input  1  serial input, idle high, asynchronous to clk
cfg_en  input  1  receiver enable
cfg_baud_div  input  8  oversample tick every cfg_baud_div+1 clocks
cfg_data_len  input  4  data bits minus 1; legal 4..7 (5..8 bits); values above 7 treated as 7
cfg_parity_en  input  1  parity bit present
cfg_parity_type  input  2  00 even, 01 odd, 10 mark(1), 11 space(0)
cfg_stop_bits  input  2  00 one stop bit, others two
rx_data  output  8  received character, LSB-aligned, unused MSBs zero
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready
parity_err  output  1  parity mismatch for current rx_data (valid with rx_valid)
frame_err  output  1  a stop bit sampled low for current rx_data
break_det  output  1  current rx_data is a break (all data, parity and stop samples 0)
overrun_err  output  1  one-cycle pulse: completed frame dropped
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (arst_n low, asynchronous): FSM IDLE; all outputs 0; synchronizer flops preset to 1.
- rx passes through SYNC_STAGES flops. All sampling uses the synchronized value.
- Tick generator: counter runs 0..cfg_baud_div and emits a tick on terminal count. It is held at 0 in IDLE. Bit period = 16*(cfg_baud_div+1) clocks.
- cfg_* are captured into shadow registers on the start-edge cycle and held constant for the whole frame.
- FSM states:
  - IDLE: a synchronized 1->0 transition with cfg_en=1 moves to START and clears the tick and sample counters.
  - START: on tick 7, if the line is 1 (false start) go to IDLE with no output; if 0, go to DATA.
  - DATA: sample every 16 ticks at mid-bit, LSB first, until data_len+1 bits are taken. Then go to PARITY if parity is enabled, else STOP1.
  - PARITY: compare the sample against the expected value. Even/odd is computed over the data bits only; mark expects 1, space expects 0.
  - STOP1: sample the stop bit; a 0 sets the frame flag. Go to STOP2 if two stop bits, else DONE.
  - STOP2: same check as STOP1, then go to DONE.
  - DONE: single cycle. Load the holding register, then return to IDLE.
- Return to IDLE happens at mid-stop, so a new start edge is detectable half a bit early.
- Holding register load in DONE:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 in that same cycle: load rx_data/parity_err/frame_err/break_det and set rx_valid.
  - If rx_valid=1 and rx_ready=0: keep the old contents, drop the new frame, pulse overrun_err for one cycle.
- rx_valid & rx_ready with no DONE in that cycle: clear rx_valid and all three error flags.
- Latency: rx_valid rises exactly 1 clock after the tick that samples the final stop bit.
- break_det implies frame_err=1.
- cfg_en deasserted: the FSM returns to IDLE on the next clock and any partial frame is discarded with no output. The holding register and its handshake keep operating.
- Mid-frame cfg_* changes have no effect until the next start edge.

Test Plan:
1. cfg_baud_div=1 (32 clk/bit), 8N1, send 0xA5 -> rx_data=0xA5, rx_valid=1 one clock after the stop-bit tick; all error flags 0; busy low after mid-stop.
2. 7 data bits (cfg_data_len=6), even parity, send 0x35 with parity bit 0, then the same frame with parity bit 1 -> first: rx_data=0x35, parity_err=0; second: parity_err=1, frame_err=0.
3. Two stop bits, drive the second stop bit low -> frame_err=1, break_det=0. Then a 400-clock low pulse with 8N1 -> rx_data=0x00, frame_err=1, break_det=1.
4. Hold rx_ready=0 and send 0x11 then 0x22 -> rx_data stays 0x11; overrun_err pulses once at the second DONE. Repeat with rx_ready=1 in exactly the DONE cycle -> rx_data=0x22, rx_valid stays 1, no overrun.
5. 0-pulse of 10 clocks (shorter than a half bit) -> FSM returns to IDLE, no rx_valid. Pull cfg_en=0 mid-DATA -> busy drops within 1 clock, no rx_valid.
6. arst_n asserted mid-frame -> all outputs 0 immediately. After release, frame 0x5A -> received correctly.
